regfile_param: RTL and testbench

Parametrised successor to the 8x16 datapath register file. It has two combinational read ports and one synchronous write port, with same-cycle write-to-read forwarding. A sequential clear engine zeroes the whole file one register per cycle on request, with a busy/done handshake. It sits in the decode/writeback stage of the multi-cycle and pipelined CPU datapaths.

---
 rtl/regfile_param.sv | 119 +++++++++++
 tb/tb_regfile_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file with a sequential clear sweep.
// Optional `REGFILE_ZERO_REG_EN hardwires R[0] to zero.
module regfile_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic signed [DATA_W-1:0] rd_data1,
    output logic signed [DATA_W-1:0] rd_data2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              sweep_we;
    logic              ext_we;
    logic [DATA_W-1:0] r [DEPTH];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sweep_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                sweep_we = 1'b1;
                if (ptr == LAST) begin
                    state_nxt = DONE;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef REGFILE_ZERO_REG_EN
    assign ext_we = wr_en && (wr_addr != '0);
`else
    assign ext_we = wr_en;
`endif

    // External write is issued after the sweep clear so it wins on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (sweep_we) begin
                r[ptr] <= '0;
            end
            if (ext_we) begin
                r[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data1 = r[rd_addr1];
        if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end
`endif
    end

    always_comb begin
        rd_data2 = r[rd_addr2];
        if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end
`endif
    end

    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);

endmodule

// File: tb/tb_regfile_param.sv
// Randomised + directed scoreboard bench for regfile_param.
// Expected outputs come from an array model of the register file and sweep.
module tb_regfile_param;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [AW-1:0]        rd_addr1;
    logic [AW-1:0]        rd_addr2;
    logic signed [DW-1:0] rd_data1;
    logic signed [DW-1:0] rd_data2;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 clr_req;
    logic                 clr_busy;
    logic                 clr_done;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          busy;
        logic          done;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Reference model: register contents plus "which register the sweep
    // clears at the next edge" (-1 when no sweep is running).
    logic [DW-1:0] m [DEPTH];
    int            sweep_idx;
    logic          m_done;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        sweep_idx = -1;
        m_done    = 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_read(
        input logic [AW-1:0] a, input logic we,
        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        if (we && wa == a) return wd;
        return m[a];
    endfunction

    function automatic void model_edge(
        input logic we, input logic [AW-1:0] wa,
        input logic [DW-1:0] wd, input logic req);
        logic was_done;
        was_done = m_done;
        m_done   = 1'b0;
        if (sweep_idx >= 0) begin
            m[sweep_idx] = '0;
            if (sweep_idx == DEPTH - 1) begin
                sweep_idx = -1;
                m_done    = 1'b1;
            end else begin
                sweep_idx++;
            end
        end else if (!was_done && req) begin
            sweep_idx = 0;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (we && wa != 0) m[wa] = wd;
`else
        if (we) m[wa] = wd;
`endif
    endfunction

    task automatic cyc(
        input logic r_, input logic we, input logic [AW-1:0] wa,
        input logic [DW-1:0] wd, input logic [AW-1:0] a1,
        input logic [AW-1:0] a2, input logic req);
        exp_t e;
        rst      = r_;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
        clr_req  = req;
        if (r_) model_reset();
        e.d1   = model_read(a1, we, wa, wd);
        e.d2   = model_read(a2, we, wa, wd);
        e.busy = (sweep_idx >= 0);
        e.done = m_done;
        e.cyc  = cyc_no;
        q.push_back(e);
        @(posedge clk);
        if (!r_) model_edge(we, wa, wd, req);
        cyc_no++;
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        cyc(1'b0, 1'b0, '0, '0, a1, a2, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        cyc(1'b0, 1'b1, wa, wd, wa, 3'(wa + 1), 1'b0);
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) wr(3'(i), 16'(16'h1111 * i));
    endtask

    // Monitor: outputs are sampled mid-cycle and checked against the queue.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks += 4;
            if (rd_data1 !== e.d1) begin
                n_fail++;
                $display("FAIL rd_data1 cyc %0d: got %h want %h",
                         e.cyc, rd_data1, e.d1);
            end
            if (rd_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL rd_data2 cyc %0d: got %h want %h",
                         e.cyc, rd_data2, e.d2);
            end
            if (clr_busy !== e.busy) begin
                n_fail++;
                $display("FAIL clr_busy cyc %0d: got %b want %b",
                         e.cyc, clr_busy, e.busy);
            end
            if (clr_done !== e.done) begin
                n_fail++;
                $display("FAIL clr_done cyc %0d: got %b want %b",
                         e.cyc, clr_done, e.done);
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, '0, '0, 3'd3, 3'd5, 1'b0);
        idle(3'd0, 3'd7);

        // Basic writes and signed readback.
        wr(3'd3, 16'h1234);
        wr(3'd5, 16'hFFFE);
        idle(3'd3, 3'd5);

        // Same-cycle forwarding, then the registered value.
        cyc(1'b0, 1'b1, 3'd2, 16'h00AA, 3'd2, 3'd3, 1'b0);
        idle(3'd2, 3'd5);

        // Full sweep, watching progressive clearing.
        load_all();
        cyc(1'b0, 1'b0, '0, '0, 3'd0, 3'd7, 1'b1);
        for (int k = 0; k < DEPTH + 3; k++) idle(3'(k), 3'(k + 1));

        // Writes racing the sweep and a redundant request.
        load_all();
        cyc(1'b0, 1'b0, '0, '0, 3'd6, 3'd1, 1'b1);
        for (int k = 0; k < DEPTH + 3; k++) begin
            if (k == 2)      cyc(1'b0, 1'b1, 3'd6, 16'h0BAD, 3'd6, 3'd1, 1'b0);
            else if (k == 4) cyc(1'b0, 1'b1, 3'd1, 16'h0C0D, 3'd6, 3'd1, 1'b0);
            else if (k == 3 || k == 8)
                cyc(1'b0, 1'b0, '0, '0, 3'd6, 3'd1, 1'b1);
            else idle(3'd6, 3'd1);
        end
        // Write landing on the address being swept this cycle.
        load_all();
        cyc(1'b0, 1'b0, '0, '0, 3'd3, 3'd4, 1'b1);
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k == 3) cyc(1'b0, 1'b1, 3'd3, 16'h7E57, 3'd3, 3'd4, 1'b0);
            else idle(3'd3, 3'(k));
        end

        // Reset mid-sweep, then a fresh full sweep.
        load_all();
        cyc(1'b0, 1'b0, '0, '0, 3'd4, 3'd7, 1'b1);
        for (int k = 0; k < 3; k++) idle(3'd4, 3'd7);
        cyc(1'b1, 1'b0, '0, '0, 3'd4, 3'd7, 1'b0);
        for (int k = 0; k < 3; k++) idle(3'(k), 3'(k + 4));
        load_all();
        cyc(1'b0, 1'b0, '0, '0, 3'd0, 3'd7, 1'b1);
        for (int k = 0; k < DEPTH + 3; k++) idle(3'(k), 3'(7 - k));

        // Register 0 behaviour (hardwired only with the zero-reg macro).
        cyc(1'b0, 1'b1, 3'd0, 16'h5555, 3'd0, 3'd1, 1'b0);
        idle(3'd0, 3'd0);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            logic r_, we, req;
            r_  = ($urandom_range(0, 149) == 0);
            we  = r_ ? 1'b0 : 1'($urandom_range(0, 1));
            req = ($urandom_range(0, 11) == 0);
            cyc(r_, we, 3'($urandom), 16'($urandom),
                3'($urandom), 3'($urandom), req);
        end
        idle('0, '0);

        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
